// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - word-addressed on-chip memory answering read/write burst requests
//
// Purpose: responder end of the core read/write burst interface. Read and
// write channels each run a small two-state FSM and may be active at the
// same time. Memory contents survive reset.
//
// Optional feature macro: BURST_MEM_FIXED_EN
//   defined   - burst=0 (FIXED) holds the word index for every beat
//   undefined - every burst is treated as INCR
//
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   read_request_valid/ready                 read request handshake
//   read_addr/len/size/burst                 read request fields
//   read_data, read_data_valid/ready         read beat stream
//   write_request_valid/ready                write request handshake
//   write_addr/len/size/burst                write request fields
//   write_data, write_data_valid/ready       write beat stream
module burst_mem_responder #(
  parameter int AXI_AWIDTH     = 32,
  parameter int AXI_DWIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_request_valid,
  output logic                  read_request_ready,
  input  logic [AXI_AWIDTH-1:0] read_addr,
  input  logic [31:0]           read_len,
  input  logic [2:0]            read_size,
  input  logic [1:0]            read_burst,
  output logic [AXI_DWIDTH-1:0] read_data,
  output logic                  read_data_valid,
  input  logic                  read_data_ready,
  input  logic                  write_request_valid,
  output logic                  write_request_ready,
  input  logic [AXI_AWIDTH-1:0] write_addr,
  input  logic [31:0]           write_len,
  input  logic [2:0]            write_size,
  input  logic [1:0]            write_burst,
  input  logic [AXI_DWIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  write_data_ready
);

  localparam int IW    = MEM_DEPTH_LOG2;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef enum logic { R_IDLE = 1'b0, R_BURST = 1'b1 } r_state_t;
  typedef enum logic { W_IDLE = 1'b0, W_DATA  = 1'b1 } w_state_t;

  logic [AXI_DWIDTH-1:0] mem [0:DEPTH-1];

  r_state_t    r_state, r_state_next;
  logic [IW-1:0] r_index;
  logic [32:0]   r_remaining;   // 33 bits so len=0xFFFFFFFF gives 2^32 beats
  logic          r_fixed;

  w_state_t    w_state, w_state_next;
  logic [IW-1:0] w_index;
  logic [32:0]   w_remaining;
  logic          w_fixed;

  logic rd_req_fire, rd_beat_fire, rd_last;
  logic wr_req_fire, wr_beat_fire, wr_last;
  logic rd_fixed_in, wr_fixed_in;

`ifdef BURST_MEM_FIXED_EN
  assign rd_fixed_in = (read_burst == 2'b00);
  assign wr_fixed_in = (write_burst == 2'b00);
`else
  assign rd_fixed_in = 1'b0;
  assign wr_fixed_in = 1'b0;
`endif

  // Size, byte offset and upper address bits carry no meaning here.
  logic unused_fields;
  assign unused_fields = &{1'b0, read_size, write_size, read_burst, write_burst,
                           read_addr, write_addr};

  assign rd_req_fire  = read_request_valid && read_request_ready;
  assign rd_beat_fire = read_data_valid && read_data_ready;
  assign rd_last      = (r_remaining == 33'd1);
  assign wr_req_fire  = write_request_valid && write_request_ready;
  assign wr_beat_fire = write_data_valid && write_data_ready;
  assign wr_last      = (w_remaining == 33'd1);

  // ---------------- read channel ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_req_fire) r_state_next = R_BURST;
      R_BURST: if (rd_beat_fire && rd_last) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // read_data is an array read addressed by a register, so it does not
  // depend on read_data_ready. A write landing on the same word this cycle
  // only takes effect at the edge, so the presented beat shows old data.
  always_comb begin
    read_request_ready = (r_state == R_IDLE);
    read_data_valid    = (r_state == R_BURST);
    read_data          = '0;
    if (r_state == R_BURST) read_data = mem[r_index];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index     <= '0;
      r_remaining <= '0;
      r_fixed     <= 1'b0;
    end else if (rd_req_fire) begin
      r_index     <= read_addr[IW+1:2];
      r_remaining <= {1'b0, read_len} + 33'd1;
      r_fixed     <= rd_fixed_in;
    end else if (rd_beat_fire) begin
      r_index     <= r_fixed ? r_index : r_index + 1'b1;  // wraps at depth
      r_remaining <= r_remaining - 33'd1;
    end
  end

  // ---------------- write channel ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE: if (wr_req_fire) w_state_next = W_DATA;
      W_DATA: if (wr_beat_fire && wr_last) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    write_request_ready = (w_state == W_IDLE);
    write_data_ready    = (w_state == W_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_index     <= '0;
      w_remaining <= '0;
      w_fixed     <= 1'b0;
    end else if (wr_req_fire) begin
      w_index     <= write_addr[IW+1:2];
      w_remaining <= {1'b0, write_len} + 33'd1;
      w_fixed     <= wr_fixed_in;
    end else if (wr_beat_fire) begin
      w_index     <= w_fixed ? w_index : w_index + 1'b1;
      w_remaining <= w_remaining - 33'd1;
    end
  end

  // Memory is never reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (wr_beat_fire) mem[w_index] <= write_data;
  end

endmodule
